// File: rtl/ice40_pll_pad_model_pkg.sv
// ice40_pll_pkg: shared constants and elaboration helpers for the
// behavioural iCE40 pad PLL model. Optional feature macro: PLL_LOCK_EN.
package ice40_pll_pkg;

   // Legal ranges of the vendor divider fields and of the model knobs.
   localparam int DIVR_MAX         = 15;
   localparam int DIVF_MAX         = 127;
   localparam int DIVQ_MAX         = 7;
   localparam int FILTER_RANGE_MAX = 7;
   localparam int ACC_W_MIN        = 8;
   localparam int ACC_W_MAX        = 48;

   // Phase increment: floor(ref*(divf+1)*2^acc_w / ((divr+1)*2^divq*clk)).
   // 128-bit intermediates keep the numerator exact for every legal setting.
   function automatic logic [127:0] calc_pll_inc(
      input longint unsigned ref_hz,
      input longint unsigned clk_hz,
      input int              divr,
      input int              divf,
      input int              divq,
      input int              acc_w
   );
      logic [127:0] num;
      logic [127:0] den;
      num = 128'(ref_hz) * 128'(divf + 1);
      num = num << acc_w;
      den = 128'(divr + 1) * 128'(clk_hz);
      den = den << divq;
      return num / den;
   endfunction

   // True when every parameter is in range and the NCO output stays
   // strictly below half the model clock (INC < 2^(acc_w-1), INC != 0).
   function automatic bit pll_params_legal(
      input bit           fb_simple,
      input int           divr,
      input int           divf,
      input int           divq,
      input int           filter_range,
      input int           acc_w,
      input int           lock_cycles,
      input logic [127:0] inc
   );
      bit ok;
      ok = fb_simple;
      if (divr < 0 || divr > DIVR_MAX) ok = 1'b0;
      if (divf < 0 || divf > DIVF_MAX) ok = 1'b0;
      if (divq < 0 || divq > DIVQ_MAX) ok = 1'b0;
      if (filter_range < 0 || filter_range > FILTER_RANGE_MAX) ok = 1'b0;
      if (acc_w < ACC_W_MIN || acc_w > ACC_W_MAX) ok = 1'b0;
      if (lock_cycles < 1) ok = 1'b0;
      if (inc == 128'd0) ok = 1'b0;
      if (acc_w >= 1 && inc >= (128'd1 << (acc_w - 1))) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/ice40_pll_pad_model_if.sv
// Pad-side signal bundle of the PLL model. The environment (board or bench)
// drives the reference pin and bypass select; the PLL drives the outputs.
// lock is only driven by the model when PLL_LOCK_EN is defined.
interface ice40_pll_pad_model_if;
   logic package_pin;
   logic bypass;
   logic pllout_core;
   logic pllout_global;
   logic lock;

   modport master (
      output package_pin, bypass,
      input  pllout_core, pllout_global, lock
   );

   modport slave (
      input  package_pin, bypass,
      output pllout_core, pllout_global, lock
   );
endinterface

// File: rtl/ice40_pll_pad_model_nco.sv
// pll_nco: phase accumulator plus the single output register of the model.
// The output register takes the new accumulator MSB while advancing, an
// external value when sel_ext is set (bypass), and 0 otherwise (pre-lock).
module pll_nco #(
   parameter int               ACC_W = 24,
   parameter logic [ACC_W-1:0] INC   = {{(ACC_W-1){1'b0}}, 1'b1}
) (
   input  logic clk,
   input  logic rst,
   input  logic advance,
   input  logic sel_ext,
   input  logic ext_val,
   output logic out
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic             out_q, out_d;

   // Next phase and next output level; the phase holds whenever not advancing.
   always_comb begin
      acc_d = acc_q;
      out_d = 1'b0;
      if (advance) begin
         acc_d = acc_q + INC;
      end
      if (sel_ext) begin
         out_d = ext_val;
      end else if (advance) begin
         out_d = acc_d[ACC_W-1];
      end
   end

   // Accumulator and output register, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         out_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: rtl/ice40_pll_pad_model.sv
// ice40_pll_pad_model: behavioural stand-in for the iCE40 pad-fed PLL.
// Output is an NCO square wave at REF_HZ*(DIVF+1)/((DIVR+1)*2^DIVQ).
// Optional feature macro: PLL_LOCK_EN (adds the lock port and a start-up
// lock counter that holds the NCO until LOCK_CYCLES edges have elapsed).
module ice40_pll_pad_model
   import ice40_pll_pkg::*;
#(
   parameter longint unsigned REF_HZ        = 64'd12000000,
   parameter longint unsigned CLK_HZ        = 64'd200000000,
   parameter int              DIVR          = 0,
   parameter int              DIVF          = 51,
   parameter int              DIVQ          = 5,
   parameter int              FILTER_RANGE  = 1,
   parameter string           FEEDBACK_PATH = "SIMPLE",
   parameter int              ACC_W         = 24,
   parameter int              LOCK_CYCLES   = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic package_pin,
   input  logic bypass,
   output logic pllout_core,
`ifdef PLL_LOCK_EN
   output logic pllout_global,
   output logic lock
`else
   output logic pllout_global
`endif
);

   localparam logic [127:0]     INC_WIDE  = calc_pll_inc(REF_HZ, CLK_HZ, DIVR, DIVF, DIVQ, ACC_W);
   localparam logic [ACC_W-1:0] INC       = INC_WIDE[ACC_W-1:0];
   localparam bit               FB_SIMPLE = (FEEDBACK_PATH == "SIMPLE");
   localparam bit               PARAMS_OK = pll_params_legal(FB_SIMPLE, DIVR, DIVF, DIVQ,
                                                             FILTER_RANGE, ACC_W, LOCK_CYCLES,
                                                             INC_WIDE);

   // Refuse to build an illegal configuration rather than model it wrongly.
   if (!FB_SIMPLE) begin : g_bad_feedback
      $error("ice40_pll_pad_model: FEEDBACK_PATH must be \"SIMPLE\"");
   end
   if (!PARAMS_OK) begin : g_bad_params
      $error("ice40_pll_pad_model: parameters out of range or INC not in 1..2^(ACC_W-1)-1");
   end

   logic ref_q, ref_d;
   logic nco_run;
   logic advance;
   logic out;

   // Reference pin is sampled every edge regardless of bypass, so bypass
   // output lags the pin by exactly two edges.
   always_comb begin
      ref_d = package_pin;
   end

   // Reference sampling register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_q <= 1'b0;
      end else begin
         ref_q <= ref_d;
      end
   end

`ifdef PLL_LOCK_EN
   localparam int CNT_W = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lock_q, lock_d;

   // Saturating edge counter; lock rises on the edge the count hits LOCK_CYCLES.
   always_comb begin
      cnt_d  = cnt_q;
      lock_d = lock_q;
      if (cnt_q != CNT_W'(LOCK_CYCLES)) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CNT_W'(LOCK_CYCLES)) begin
         lock_d = 1'b1;
      end
   end

   // Lock counter and lock flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         lock_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         lock_q <= lock_d;
      end
   end

   // The NCO starts on the edge after lock has risen.
   assign nco_run = lock_q;
   assign lock    = lock_q;
`else
   assign nco_run = 1'b1;
`endif

   assign advance = ~bypass & nco_run;

   pll_nco #(
      .ACC_W (ACC_W),
      .INC   (INC)
   ) u_nco (
      .clk     (clk),
      .rst     (reset),
      .advance (advance),
      .sel_ext (bypass),
      .ext_val (ref_q),
      .out     (out)
   );

   assign pllout_core   = out;
   assign pllout_global = out;

endmodule

// File: tb/tb_ice40_pll_pad_model.sv
// Bench for ice40_pll_pad_model: DUT A uses REF=CLK=100 MHz, DIVQ=2
// (INC=2^22) for exact sequence vectors; DUT B uses the default settings
// for the long-run frequency and duty-cycle measurement.
module tb_ice40_pll_pad_model;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  ice40_pll_pad_model_if pins_a ();
  ice40_pll_pad_model_if pins_b ();

  ice40_pll_pad_model #(
    .REF_HZ (64'd100000000),
    .CLK_HZ (64'd100000000),
    .DIVR   (0),
    .DIVF   (0),
    .DIVQ   (2),
    .ACC_W  (24)
  ) dut_a (
    .clk           (clk),
    .reset         (rst_a),
    .package_pin   (pins_a.package_pin),
    .bypass        (pins_a.bypass),
    .pllout_core   (pins_a.pllout_core),
`ifdef PLL_LOCK_EN
    .pllout_global (pins_a.pllout_global),
    .lock          (pins_a.lock)
`else
    .pllout_global (pins_a.pllout_global)
`endif
  );

  ice40_pll_pad_model dut_b (
    .clk           (clk),
    .reset         (rst_b),
    .package_pin   (pins_b.package_pin),
    .bypass        (pins_b.bypass),
    .pllout_core   (pins_b.pllout_core),
`ifdef PLL_LOCK_EN
    .pllout_global (pins_b.pllout_global),
    .lock          (pins_b.lock)
`else
    .pllout_global (pins_b.pllout_global)
`endif
  );

`ifndef PLL_LOCK_EN
  assign pins_a.lock = 1'b0;
  assign pins_b.lock = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic pin;
    logic byp;
    logic exp_out;
  } vec_t;

  vec_t vecs[24];

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic set_vec(input int i, input logic pin, input logic byp, input logic exp_out);
    vecs[i].pin     = pin;
    vecs[i].byp     = byp;
    vecs[i].exp_out = exp_out;
  endtask

  // Drive inputs ahead of the next edge, then sample 1 time unit after it.
  task automatic step_a(input logic pin, input logic byp);
    pins_a.package_pin = pin;
    pins_a.bypass      = byp;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vecs(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      step_a(vecs[i].pin, vecs[i].byp);
      check_bit($sformatf("%s_core_e%0d", tag, i + 1), pins_a.pllout_core, vecs[i].exp_out);
      check_bit($sformatf("%s_glob_e%0d", tag, i + 1), pins_a.pllout_global, vecs[i].exp_out);
    end
  endtask

  // With the lock feature the NCO is held for 16 edges; outputs stay 0.
  task automatic wait_lock_a();
`ifdef PLL_LOCK_EN
    for (int e = 1; e <= 16; e++) begin
      step_a(1'b0, 1'b0);
      check_bit($sformatf("lock_e%0d", e), pins_a.lock, (e == 16) ? 1'b1 : 1'b0);
      check_bit($sformatf("lock_out_e%0d", e), pins_a.pllout_core, 1'b0);
    end
`endif
  endtask

  int   rises;
  int   max_run;
  int   run_len;
  int   glob_diff;
  logic prev;

  initial begin
    // Edges 1..8: plain NCO, INC = quarter turn -> 0,1,1,0 repeating.
    set_vec(0,  1'b0, 1'b0, 1'b0);
    set_vec(1,  1'b0, 1'b0, 1'b1);
    set_vec(2,  1'b0, 1'b0, 1'b1);
    set_vec(3,  1'b0, 1'b0, 1'b0);
    set_vec(4,  1'b0, 1'b0, 1'b0);
    set_vec(5,  1'b0, 1'b0, 1'b1);
    set_vec(6,  1'b0, 1'b0, 1'b1);
    set_vec(7,  1'b0, 1'b0, 1'b0);
    // Edges 9..10: advance to acc = 2^23 before entering bypass.
    set_vec(8,  1'b0, 1'b0, 1'b0);
    set_vec(9,  1'b0, 1'b0, 1'b1);
    // Edges 11..20: bypass, pin toggles every 3 edges, out = pin two edges late.
    set_vec(10, 1'b1, 1'b1, 1'b0);
    set_vec(11, 1'b1, 1'b1, 1'b1);
    set_vec(12, 1'b1, 1'b1, 1'b1);
    set_vec(13, 1'b0, 1'b1, 1'b1);
    set_vec(14, 1'b0, 1'b1, 1'b0);
    set_vec(15, 1'b0, 1'b1, 1'b0);
    set_vec(16, 1'b1, 1'b1, 1'b0);
    set_vec(17, 1'b1, 1'b1, 1'b1);
    set_vec(18, 1'b1, 1'b1, 1'b1);
    set_vec(19, 1'b0, 1'b1, 1'b1);
    // Edges 21..24: NCO resumes from held acc = 2^23 -> 3/4, 0, 1/4, 1/2 turn.
    set_vec(20, 1'b0, 1'b0, 1'b1);
    set_vec(21, 1'b0, 1'b0, 1'b0);
    set_vec(22, 1'b1, 1'b0, 1'b0);
    set_vec(23, 1'b1, 1'b0, 1'b1);

    rst_a = 1'b1;
    rst_b = 1'b1;
    pins_a.package_pin = 1'b0;
    pins_a.bypass      = 1'b0;
    pins_b.package_pin = 1'b0;
    pins_b.bypass      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_a_core", pins_a.pllout_core, 1'b0);
    check_bit("rst_a_glob", pins_a.pllout_global, 1'b0);
    check_bit("rst_b_core", pins_b.pllout_core, 1'b0);
    check_bit("rst_a_lock", pins_a.lock, 1'b0);

    // Long run on default settings: ~1950 cycles of output in 20000 clocks.
    @(negedge clk);
    rst_b = 1'b0;
`ifdef PLL_LOCK_EN
    repeat (16) @(posedge clk);
    #1;
`endif
    rises     = 0;
    max_run   = 0;
    run_len   = 0;
    glob_diff = 0;
    prev      = pins_b.pllout_core;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      #1;
      if (pins_b.pllout_global !== pins_b.pllout_core) glob_diff++;
      if (pins_b.pllout_core === prev) begin
        run_len++;
      end else begin
        if (run_len > max_run) max_run = run_len;
        run_len = 1;
        if (pins_b.pllout_core === 1'b1) rises++;
      end
      prev = pins_b.pllout_core;
    end
    if (run_len > max_run) max_run = run_len;
    check_range("dflt_rises", rises, 1949, 1951);
    check_range("dflt_max_run", max_run, 1, 6);
    check_range("dflt_glob_diff", glob_diff, 0, 0);

    // Exact sequences on DUT A.
    @(negedge clk);
    rst_a = 1'b0;
    wait_lock_a();
    run_vecs(0, 23, "seq");

    // Output is high now; reset must clear it without waiting for an edge.
    #2;
    rst_a = 1'b1;
    #1;
    check_bit("async_rst_core", pins_a.pllout_core, 1'b0);
    check_bit("async_rst_glob", pins_a.pllout_global, 1'b0);
    @(posedge clk);
    #1;
    check_bit("held_rst_core", pins_a.pllout_core, 1'b0);
    @(negedge clk);
    rst_a = 1'b0;
    wait_lock_a();
    run_vecs(0, 7, "restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
